mul24_share_ctrl: RTL

- Sequencing and arbitration controller for one shared 24x24 unsigned significand multiplier (instance of mul_24bits, kept inside this block).
- Two requesters, for example two FP multiply lanes, each present a significand pair. The block grants one requester round-robin and registers its operands.
- The mul_24bits ripple-add chain is a multicycle path. The block waits MUL_CYCLES clocks before capturing the 48-bit product, then returns it through a valid/ready response port tagged with the requester id.

---
 rtl/mul24_share_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mul24_share_ctrl.sv
// Round-robin sequencer that shares one 24x24 unsigned multiplier between two requesters.
// The multiplier is treated as a multicycle path; the product is captured MUL_CYCLES clocks later.

module mul_24bits (
    input  logic [23:0] i_a,
    input  logic [23:0] i_b,
    output logic [47:0] o_p
);
    // Shift-and-add ripple chain: deliberately slow, covered by the controller's wait count.
    always_comb begin
        o_p = '0;
        for (int i = 0; i < 24; i++) begin
            if (i_b[i]) begin
                o_p = o_p + ({24'd0, i_a} << i);
            end
        end
    end
endmodule

module mul24_share_ctrl #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [23:0] i_req0_data_one,
    input  logic [23:0] i_req0_data_two,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [23:0] i_req1_data_one,
    input  logic [23:0] i_req1_data_two,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic        o_rsp_id,
    output logic [47:0] o_rsp_data,
    output logic        o_busy
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t      state_q;
    logic [3:0]  count_q;
    logic        last_id_q;
    logic        id_q;
    logic [23:0] op_a_q;
    logic [23:0] op_b_q;
    logic [47:0] rsp_data_q;
    logic        rsp_id_q;
    logic        rsp_valid_q;
    logic [47:0] product;
    logic        grant_valid;
    logic        grant_id;

    mul_24bits u_mul (
        .i_a (op_a_q),
        .i_b (op_b_q),
        .o_p (product)
    );

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_valid = i_req0_valid | i_req1_valid;
        grant_id    = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant_id = ~last_id_q;
        end else begin
            grant_id = i_req1_valid;
        end
    end

    // Readies are masked during reset so both read 0 while reset is held.
    assign o_req0_ready = ~i_rst & (state_q == StIdle) & grant_valid & ~grant_id;
    assign o_req1_ready = ~i_rst & (state_q == StIdle) & grant_valid &  grant_id;
    assign o_busy       = (state_q != StIdle);
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_data   = rsp_data_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            last_id_q   <= 1'b1;
            id_q        <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        op_a_q    <= grant_id ? i_req1_data_one : i_req0_data_one;
                        op_b_q    <= grant_id ? i_req1_data_two : i_req0_data_two;
                        id_q      <= grant_id;
                        last_id_q <= grant_id;
                        count_q   <= 4'(MUL_CYCLES - 1);
                        state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    if (count_q == 4'd0) begin
                        rsp_data_q  <= product;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                StDone: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
